// File: rtl/psum_accum.sv
// Partial-sum accumulator: adds bias on the first pass, saturating-accumulates N Pin slices per pixel.
// Optional PSUM_ACCUM_RELU_EN clamps negative final lanes to zero (intermediate sums stay signed).
module psum_accum #(
   parameter int Pout       = 1,
   parameter int BIT_WIDTH  = 8,
   parameter int PASS_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [PASS_WIDTH-1:0]     cfg_num_pass,
   input  logic                      accum_clear,
   input  logic                      add_array_valid,
   input  logic [Pout*BIT_WIDTH-1:0] add_array_data,
   input  logic [Pout*BIT_WIDTH-1:0] bias_data,
   output logic                      accum_busy,
   output logic                      accum_valid,
   output logic [Pout*BIT_WIDTH-1:0] accum_data
);

   logic [PASS_WIDTH-1:0]     pass_cnt_q;
   logic [PASS_WIDTH-1:0]     num_pass_q;
   logic [Pout*BIT_WIDTH-1:0] acc_q;
   logic                      accum_valid_q;
   logic [Pout*BIT_WIDTH-1:0] accum_data_q;

   logic                      first_pass;
   logic [PASS_WIDTH-1:0]     cfg_eff;
   logic [PASS_WIDTH-1:0]     num_pass_eff;
   logic                      last_pass;
   logic [Pout*BIT_WIDTH-1:0] sum_d;
   logic [Pout*BIT_WIDTH-1:0] post_d;
   logic [BIT_WIDTH-1:0]      lane_a;
   logic [BIT_WIDTH-1:0]      lane_b;
   logic [BIT_WIDTH:0]        lane_wide;
   logic [BIT_WIDTH-1:0]      lane_sat;

   assign first_pass   = (pass_cnt_q == '0);
   assign cfg_eff      = (cfg_num_pass == '0) ? PASS_WIDTH'(1) : cfg_num_pass;
   assign num_pass_eff = first_pass ? cfg_eff : num_pass_q;
   assign last_pass    = (pass_cnt_q == num_pass_eff - PASS_WIDTH'(1));

   // Sign-extend by one bit; disagreement of the top two bits means overflow.
   always_comb begin
      sum_d     = '0;
      post_d    = '0;
      lane_a    = '0;
      lane_b    = '0;
      lane_wide = '0;
      lane_sat  = '0;
      for (int unsigned i = 0; i < Pout; i++) begin
         lane_a    = first_pass ? bias_data[i*BIT_WIDTH +: BIT_WIDTH] : acc_q[i*BIT_WIDTH +: BIT_WIDTH];
         lane_b    = add_array_data[i*BIT_WIDTH +: BIT_WIDTH];
         lane_wide = {lane_a[BIT_WIDTH-1], lane_a} + {lane_b[BIT_WIDTH-1], lane_b};
         if (lane_wide[BIT_WIDTH] != lane_wide[BIT_WIDTH-1]) begin
            lane_sat = lane_wide[BIT_WIDTH] ? {1'b1, {(BIT_WIDTH-1){1'b0}}}
                                            : {1'b0, {(BIT_WIDTH-1){1'b1}}};
         end else begin
            lane_sat = lane_wide[BIT_WIDTH-1:0];
         end
         sum_d[i*BIT_WIDTH +: BIT_WIDTH] = lane_sat;
`ifdef PSUM_ACCUM_RELU_EN
         post_d[i*BIT_WIDTH +: BIT_WIDTH] = lane_sat[BIT_WIDTH-1] ? '0 : lane_sat;
`else
         post_d[i*BIT_WIDTH +: BIT_WIDTH] = lane_sat;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pass_cnt_q    <= '0;
         num_pass_q    <= '0;
         acc_q         <= '0;
         accum_valid_q <= 1'b0;
         accum_data_q  <= '0;
      end else begin
         accum_valid_q <= 1'b0;
         if (accum_clear) begin
            pass_cnt_q <= '0;
         end else if (add_array_valid) begin
            if (first_pass) begin
               num_pass_q <= cfg_eff;
            end
            if (last_pass) begin
               accum_data_q  <= post_d;
               accum_valid_q <= 1'b1;
               pass_cnt_q    <= '0;
            end else begin
               acc_q      <= sum_d;
               pass_cnt_q <= pass_cnt_q + PASS_WIDTH'(1);
            end
         end
      end
   end

   assign accum_busy  = !first_pass;
   assign accum_valid = accum_valid_q;
   assign accum_data  = accum_data_q;

endmodule

// File: tb/tb_psum_accum.sv
// Bench for psum_accum (Pout=2, BIT_WIDTH=8): integer reference model checked every cycle,
// directed literal cases, then randomized traffic. Honors PSUM_ACCUM_RELU_EN.
module tb_psum_accum;

   localparam int P  = 2;
   localparam int W  = 8;
   localparam int PW = 8;
   localparam int MAXV = (1 << (W-1)) - 1;
   localparam int MINV = -(1 << (W-1));

   logic            clk = 1'b0;
   logic            rst;
   logic [PW-1:0]   cfg_num_pass;
   logic            accum_clear;
   logic            add_array_valid;
   logic [P*W-1:0]  add_array_data;
   logic [P*W-1:0]  bias_data;
   logic            accum_busy;
   logic            accum_valid;
   logic [P*W-1:0]  accum_data;

   int total = 0;
   int bad   = 0;

   // reference model state
   int m_cnt;
   int m_np;
   int m_acc [P];
   int m_out [P];
   bit m_valid;
   int valid_seen;
   int busy_seen;

   psum_accum #(.Pout(P), .BIT_WIDTH(W), .PASS_WIDTH(PW)) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_num_pass    (cfg_num_pass),
      .accum_clear     (accum_clear),
      .add_array_valid (add_array_valid),
      .add_array_data  (add_array_data),
      .bias_data       (bias_data),
      .accum_busy      (accum_busy),
      .accum_valid     (accum_valid),
      .accum_data      (accum_data)
   );

   always #5 clk = ~clk;

   function automatic int sat(input int x);
      if (x > MAXV) return MAXV;
      if (x < MINV) return MINV;
      return x;
   endfunction

   function automatic int post(input int x);
`ifdef PSUM_ACCUM_RELU_EN
      return (x < 0) ? 0 : x;
`else
      return x;
`endif
   endfunction

   function automatic int lane(input logic [P*W-1:0] v, input int i);
      logic [W-1:0] b;
      b = v[i*W +: W];
      return int'($signed(b));
   endfunction

   function automatic logic [P*W-1:0] pack2(input int a0, input int a1);
      logic [P*W-1:0] v;
      v = '0;
      v[0 +: W] = a0[W-1:0];
      v[W +: W] = a1[W-1:0];
      return v;
   endfunction

   task automatic check(input string name, input logic [P*W-1:0] act, input logic [P*W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: apply inputs, advance the model, then compare after the edge.
   task automatic cycle(input bit r, input bit clr, input bit v, input int cfg,
                        input int d0, input int d1, input int b0, input int b1);
      int eff, s;
      int d[P];
      int b[P];
      rst             = r;
      accum_clear     = clr;
      add_array_valid = v;
      cfg_num_pass    = PW'(cfg);
      add_array_data  = pack2(d0, d1);
      bias_data       = pack2(b0, b1);
      d[0] = lane(add_array_data, 0); d[1] = lane(add_array_data, 1);
      b[0] = lane(bias_data, 0);      b[1] = lane(bias_data, 1);
      m_valid = 0;
      if (r) begin
         m_cnt = 0; m_np = 0;
         for (int i = 0; i < P; i++) begin m_acc[i] = 0; m_out[i] = 0; end
      end else if (clr) begin
         m_cnt = 0;
      end else if (v) begin
         eff = (m_cnt == 0) ? ((cfg == 0) ? 1 : cfg) : m_np;
         if (m_cnt == 0) m_np = eff;
         if (m_cnt == eff - 1) begin
            for (int i = 0; i < P; i++) m_out[i] = post(sat(((m_cnt == 0) ? b[i] : m_acc[i]) + d[i]));
            m_valid = 1;
            m_cnt = 0;
         end else begin
            for (int i = 0; i < P; i++) begin
               s = sat(((m_cnt == 0) ? b[i] : m_acc[i]) + d[i]);
               m_acc[i] = s;
            end
            m_cnt++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("valid", P*W'(accum_valid), P*W'(m_valid));
      check("busy", P*W'(accum_busy), P*W'(m_cnt != 0));
      check("data", accum_data, pack2(m_out[0], m_out[1]));
      if (accum_valid) valid_seen++;
      if (accum_busy) busy_seen++;
   endtask

   task automatic idle(input int cfg);
      cycle(0, 0, 0, cfg, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1; accum_clear = 0; add_array_valid = 0; cfg_num_pass = '0;
      add_array_data = '0; bias_data = '0;
      m_cnt = 0; m_np = 0; m_valid = 0;
      for (int i = 0; i < P; i++) begin m_acc[i] = 0; m_out[i] = 0; end
      @(negedge clk);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0, 0);
      check("reset_data", accum_data, '0);
      check("reset_flags", P*W'({accum_valid, accum_busy}), '0);

      // three-pass pixel with bias
      valid_seen = 0; busy_seen = 0;
      cycle(0, 0, 1, 3, 10, 1, 5, -2);
      cycle(0, 0, 1, 3, 20, 1, 0, 0);
      cycle(0, 0, 1, 3, 30, 1, 0, 0);
      check("p3_valid", P*W'(accum_valid), P*W'(1));
      check("p3_data", accum_data, pack2(65, 1));
      idle(3);
      check("p3_busy_cycles", P*W'(busy_seen), P*W'(2));
      check("p3_one_valid", P*W'(valid_seen), P*W'(1));

      // cfg 0 behaves as single pass
      busy_seen = 0;
      cycle(0, 0, 1, 0, 7, -3, 0, 0);
`ifdef PSUM_ACCUM_RELU_EN
      check("single_data", accum_data, pack2(7, 0));
`else
      check("single_data", accum_data, pack2(7, -3));
`endif
      check("single_valid", P*W'(accum_valid), P*W'(1));
      idle(0);
      check("single_nobusy", P*W'(busy_seen), '0);

      // per-pass saturation
      cycle(0, 0, 1, 2, 100, -100, 100, -100);
      cycle(0, 0, 1, 2, -50, 50, 0, 0);
`ifdef PSUM_ACCUM_RELU_EN
      check("sat_data", accum_data, pack2(77, 0));
`else
      check("sat_data", accum_data, pack2(77, -78));
`endif
      idle(2);

      // gaps with cfg changed mid-pixel
      valid_seen = 0;
      cycle(0, 0, 1, 2, 3, 4, 1, 2);
      idle(5); idle(5); idle(5);
      cycle(0, 0, 1, 5, 5, 6, 0, 0);
      check("gap_data", accum_data, pack2(9, 12));
      idle(5);
      check("gap_one_valid", P*W'(valid_seen), P*W'(1));

      // abort then fresh pixel
      valid_seen = 0;
      cycle(0, 0, 1, 3, 10, 10, 20, 20);
      cycle(0, 1, 1, 3, 10, 10, 20, 20);
      cycle(0, 0, 1, 3, 1, 2, 1, 1);
      cycle(0, 0, 1, 3, 3, 4, 0, 0);
      cycle(0, 0, 1, 3, 5, 6, 0, 0);
      check("abort_data", accum_data, pack2(10, 13));
      idle(3);
      check("abort_one_valid", P*W'(valid_seen), P*W'(1));

      // reset mid-pixel
      valid_seen = 0;
      cycle(0, 0, 1, 2, 40, 40, 1, 1);
      cycle(1, 0, 0, 2, 0, 0, 0, 0);
      check("rst_mid_data", accum_data, '0);
      cycle(0, 0, 1, 2, 4, 5, 2, 3);
      cycle(0, 0, 1, 2, 6, 7, 0, 0);
      check("rst_after_data", accum_data, pack2(12, 15));
      check("rst_one_valid", P*W'(valid_seen), P*W'(1));

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 9) < 7), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
               int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
